// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC clock divider scheduler.
package adc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_RELEASE
  } state_e;

  // Clocks the divider is held in reset so it latches a new ratio and parity.
  localparam int LOAD_CYCLES = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_clk_scheduler_rr_arbiter.sv
// Round-robin one-hot pick among requesters starting at a rotating pointer;
// the pointer moves past the serviced channel when adv pulses.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  input  logic [2:0]      adv_idx,
  output logic [NREQ-1:0] pick_oh,
  output logic [2:0]      pick_idx,
  output logic            any_req
);

  logic [2:0]        ptr_q;
  logic [2*NREQ-1:0] rot;
  logic [3:0]        sum;
  logic              found;

  // Doubling the request vector lets a plain shift express the wrap-around search.
  always_comb begin
    rot   = {req, req} >> ptr_q;
    sum   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + 4'(k);
      end
    end
    if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
    pick_idx = sum[2:0];
    pick_oh  = found ? ({{(NREQ-1){1'b0}}, 1'b1} << pick_idx) : '0;
    any_req  = found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv) begin
      ptr_q <= (adv_idx == 3'(NREQ - 1)) ? 3'd0 : adv_idx + 3'd1;
    end
  end

endmodule

// File: rtl/adc_clk_scheduler.sv
// Time-shares one programmable ADC clock divider among NREQ channels: grant,
// reload and restart the divider, discard SETTLE edges, strobe a burst, release.
module adc_clk_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int MW     = 13,
  parameter int BW     = 8,
  parameter int SETTLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*MW-1:0] div_m,
  input  logic [NREQ*BW-1:0] burst_len,
  input  logic               ad_clk,
  output logic [MW-1:0]      m_out,
  output logic               div_rst_n,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               sample_strobe,
  output logic               done,
  output logic [2:0]         done_id,
  output logic               err
);

  localparam int SW = clog2(SETTLE + 1);
  localparam int LW = clog2(LOAD_CYCLES + 1);

  state_e          state_q;
  logic [LW-1:0]   load_cnt;
  logic [SW-1:0]   settle_cnt;
  logic [BW-1:0]   burst_cnt;
  logic [MW-1:0]   shadow_m;
  logic [BW-1:0]   shadow_bl;
  logic [2:0]      cur_id;
  logic            ad_clk_d;
  logic            rise;

  logic [NREQ-1:0] pick_oh;
  logic [2:0]      pick_idx;
  logic            any_req;
  logic [MW-1:0]   sel_m;
  logic [BW-1:0]   sel_bl;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .adv      (state_q == ST_RELEASE),
    .adv_idx  (cur_id),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  always_comb begin
    sel_m  = '0;
    sel_bl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_m  = div_m[i*MW +: MW];
        sel_bl = burst_len[i*BW +: BW];
      end
    end
  end

  // Edge history is forced low while the divider is held so a restart never
  // inherits a stale high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ad_clk_d <= 1'b0;
    else        ad_clk_d <= div_rst_n ? ad_clk : 1'b0;
  end

  assign rise = ad_clk & ~ad_clk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      load_cnt      <= '0;
      settle_cnt    <= '0;
      burst_cnt     <= '0;
      shadow_m      <= '0;
      shadow_bl     <= '0;
      cur_id        <= '0;
      m_out         <= '0;
      div_rst_n     <= 1'b0;
      gnt           <= '0;
      busy          <= 1'b0;
      sample_strobe <= 1'b0;
      done          <= 1'b0;
      done_id       <= '0;
      err           <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable && any_req) begin
            state_q <= ST_ARB;
            busy    <= 1'b1;
          end
        end
        ST_ARB: begin
          shadow_m  <= sel_m;
          shadow_bl <= sel_bl;
          cur_id    <= pick_idx;
          if (!any_req) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end else if (sel_m < MW'(2)) begin
            done    <= 1'b1;
            err     <= 1'b1;
            done_id <= pick_idx;
            gnt     <= '0;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gnt       <= pick_oh;
            m_out     <= sel_m;
            div_rst_n <= 1'b0;
            load_cnt  <= '0;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_cnt == LW'(LOAD_CYCLES - 1)) begin
            div_rst_n  <= 1'b1;
            settle_cnt <= '0;
            state_q    <= ST_SETTLE;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (rise) begin
            if (settle_cnt == SW'(SETTLE - 1)) begin
              burst_cnt <= '0;
              if (shadow_bl == '0) begin
                state_q   <= ST_RELEASE;
                done      <= 1'b1;
                done_id   <= cur_id;
                gnt       <= '0;
                div_rst_n <= 1'b0;
              end else begin
                state_q <= ST_RUN;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (rise) begin
            sample_strobe <= 1'b1;
            burst_cnt     <= burst_cnt + 1'b1;
            if ((burst_cnt + BW'(1)) == shadow_bl) begin
              state_q   <= ST_RELEASE;
              done      <= 1'b1;
              done_id   <= cur_id;
              gnt       <= '0;
              div_rst_n <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
